// File: rtl/demux_reg_pkg.sv
// Purpose     : shared types and constants for the registered 1-to-2 demux.
// Latency     : n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   ch_state_t      - per-channel output slot state (CH_EMPTY / CH_FULL)
//   SEL_P / SEL_Q   - select encodings for the two output channels
//   DEF_WIDTH       - default data width
//   DEF_CNT_W       - default width of the optional per-channel beat counters
package demux_pkg;

    typedef enum logic {
        CH_EMPTY = 1'b0,
        CH_FULL  = 1'b1
    } ch_state_t;

    localparam logic SEL_P = 1'b0;
    localparam logic SEL_Q = 1'b1;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 8;

endpackage : demux_pkg

// File: rtl/demux_reg_out_slot.sv
// Purpose     : one-entry valid/ready output register for one demux channel.
// Latency     : 1 cycle from i_load to o_vld.
// Backpressure: holds o_dat/o_vld while i_rdy is low; drain and refill in the same cycle.
//
// Optional feature macro: DEMUX_CNT_EN
//   defined   - o_cnt counts completed output handshakes, wrapping silently.
//   undefined - no counter register; o_cnt is tied to zero.
//
// Ports:
//   clk     in   system clock
//   rst_n   in   asynchronous active-low reset; discards any held beat
//   i_load  in   an accepted input beat is routed to this slot this cycle
//   i_dat   in   data to capture when i_load is high
//   i_rdy   in   downstream consumer accepts the held beat
//   o_vld   out  slot holds a beat
//   o_dat   out  held data
//   o_cnt   out  completed output handshakes (zero when the counter is not built)
module demux_out_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_dat,
    input  logic             i_rdy,
    output logic             o_vld,
    output logic [WIDTH-1:0] o_dat,
    output logic [CNT_W-1:0] o_cnt
);

    ch_state_t        r_state;
    ch_state_t        w_state_nxt;
    logic [WIDTH-1:0] r_dat;
    logic             w_drain;

    // A handshake completes whenever the slot is full and the consumer is ready.
    assign w_drain = (r_state == CH_FULL) && i_rdy;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= CH_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic. A load always wins: if the slot is drained and
    // refilled in the same cycle it simply stays FULL with the new beat.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            CH_EMPTY: begin
                if (i_load) begin
                    w_state_nxt = CH_FULL;
                end
            end
            CH_FULL: begin
                if (i_load) begin
                    w_state_nxt = CH_FULL;
                end else if (w_drain) begin
                    w_state_nxt = CH_EMPTY;
                end
            end
            default: w_state_nxt = CH_EMPTY;
        endcase
    end

    // Data register. Only written on a load, so the value is stable while
    // the beat is held under backpressure. It is not cleared on drain;
    // consumers qualify it with o_vld.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dat <= '0;
        end else if (i_load) begin
            r_dat <= i_dat;
        end
    end

    assign o_vld = (r_state == CH_FULL);
    assign o_dat = r_dat;

`ifdef DEMUX_CNT_EN
    logic [CNT_W-1:0] r_cnt;

    // Counts delivered beats; natural wrap at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_drain) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;
`else
    assign o_cnt = '0;
`endif

endmodule : demux_out_slot

// File: rtl/demux_reg.sv
// Purpose     : registered 1-to-2 demux; routes one input stream to channel P or Q by sel.
// Latency     : 1 cycle from accepted input beat to p_valid/q_valid.
// Backpressure: d_ready follows only the selected channel; the other channel drains freely.
//
// Optional feature macro: DEMUX_CNT_EN (per-channel delivered-beat counters
// on p_cnt/q_cnt; when undefined both ports are tied to zero).
//
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   d_in     in   input data (WIDTH)
//   d_valid  in   input beat present
//   sel      in   0 routes to P, 1 routes to Q; ignored when d_valid is low
//   d_ready  out  input accepted when high together with d_valid
//   p_out    out  channel P data (WIDTH)
//   p_valid  out  channel P holds a beat
//   p_ready  in   channel P consumer accepts
//   q_out    out  channel Q data (WIDTH)
//   q_valid  out  channel Q holds a beat
//   q_ready  in   channel Q consumer accepts
//   p_cnt    out  beats delivered on P (CNT_W)
//   q_cnt    out  beats delivered on Q (CNT_W)
module demux_reg
    import demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_in,
    input  logic             d_valid,
    input  logic             sel,
    output logic             d_ready,
    output logic [WIDTH-1:0] p_out,
    output logic             p_valid,
    input  logic             p_ready,
    output logic [WIDTH-1:0] q_out,
    output logic             q_valid,
    input  logic             q_ready,
    output logic [CNT_W-1:0] p_cnt,
    output logic [CNT_W-1:0] q_cnt
);

    logic w_p_free;
    logic w_q_free;
    logic w_accept;
    logic w_load_p;
    logic w_load_q;

    // A channel can take a beat when it is empty or is being drained this
    // cycle, which gives one beat per cycle per channel.
    assign w_p_free = !p_valid || p_ready;
    assign w_q_free = !q_valid || q_ready;

    // Readiness looks only at the selected channel, so a stalled channel
    // never blocks traffic headed for the other one.
    assign d_ready  = (sel == SEL_Q) ? w_q_free : w_p_free;
    assign w_accept = d_valid && d_ready;

    assign w_load_p = w_accept && (sel == SEL_P);
    assign w_load_q = w_accept && (sel == SEL_Q);

    demux_out_slot #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_slot_p (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load_p),
        .i_dat  (d_in),
        .i_rdy  (p_ready),
        .o_vld  (p_valid),
        .o_dat  (p_out),
        .o_cnt  (p_cnt)
    );

    demux_out_slot #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_slot_q (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load_q),
        .i_dat  (d_in),
        .i_rdy  (q_ready),
        .o_vld  (q_valid),
        .o_dat  (q_out),
        .o_cnt  (q_cnt)
    );

endmodule : demux_reg

// File: tb/tb_demux_reg.sv
// Directed, table-driven bench for demux_reg (WIDTH=8, CNT_W=4).
module tb_demux_reg;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] d_in;
    logic             d_valid;
    logic             sel;
    logic             d_ready;
    logic [WIDTH-1:0] p_out;
    logic             p_valid;
    logic             p_ready;
    logic [WIDTH-1:0] q_out;
    logic             q_valid;
    logic             q_ready;
    logic [CNT_W-1:0] p_cnt;
    logic [CNT_W-1:0] q_cnt;

    int checks;
    int failures;

    demux_reg #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_in    (d_in),
        .d_valid (d_valid),
        .sel     (sel),
        .d_ready (d_ready),
        .p_out   (p_out),
        .p_valid (p_valid),
        .p_ready (p_ready),
        .q_out   (q_out),
        .q_valid (q_valid),
        .q_ready (q_ready),
        .p_cnt   (p_cnt),
        .q_cnt   (q_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       sel;
        logic       dv;
        logic [7:0] din;
        logic       pr;
        logic       qr;
        logic       e_drdy;
        logic       e_pv;
        logic [7:0] e_po;
        logic       e_qv;
        logic [7:0] e_qo;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_p_valid"}, 32'(p_valid), 32'd0);
        chk({tag, "_q_valid"}, 32'(q_valid), 32'd0);
        chk({tag, "_p_out"},   32'(p_out),   32'd0);
        chk({tag, "_q_out"},   32'(q_out),   32'd0);
        chk({tag, "_p_cnt"},   32'(p_cnt),   32'd0);
        chk({tag, "_q_cnt"},   32'(q_cnt),   32'd0);
    endtask

    initial begin
        logic [CNT_W-1:0] exp_q_cnt;

        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        d_in     = '0;
        d_valid  = 1'b0;
        sel      = 1'b0;
        p_ready  = 1'b0;
        q_ready  = 1'b0;

        //            sel dv  din    pr qr  drdy pv po     qv qo
        tbl[0]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 8'h00};
        tbl[1]  = '{1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b1, 8'h3C};
        tbl[2]  = '{1'b1, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b0, 8'h3C};
        tbl[3]  = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 8'h3C};
        tbl[4]  = '{1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 8'h3C};
        tbl[5]  = '{1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1'b1, 8'h33};
        tbl[6]  = '{1'b1, 1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 8'h33};
        tbl[7]  = '{1'b0, 1'b0, 8'h55, 1'b1, 1'b0, 1'b1, 1'b0, 8'h11, 1'b1, 8'h33};
        tbl[8]  = '{1'b0, 1'b1, 8'h40, 1'b0, 1'b1, 1'b1, 1'b1, 8'h40, 1'b0, 8'h33};
        tbl[9]  = '{1'b0, 1'b1, 8'h41, 1'b1, 1'b1, 1'b1, 1'b1, 8'h41, 1'b0, 8'h33};
        tbl[10] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h41, 1'b0, 8'h33};

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");

        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_idle("idle");

        // Table-driven routing / backpressure / simultaneous cases.
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            sel     = tbl[i].sel;
            d_valid = tbl[i].dv;
            d_in    = tbl[i].din;
            p_ready = tbl[i].pr;
            q_ready = tbl[i].qr;
            #1;
            chk($sformatf("vec%0d_d_ready", i), 32'(d_ready), 32'(tbl[i].e_drdy));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_p_valid", i), 32'(p_valid), 32'(tbl[i].e_pv));
            chk($sformatf("vec%0d_p_out", i),   32'(p_out),   32'(tbl[i].e_po));
            chk($sformatf("vec%0d_q_valid", i), 32'(q_valid), 32'(tbl[i].e_qv));
            chk($sformatf("vec%0d_q_out", i),   32'(q_out),   32'(tbl[i].e_qo));
        end

        // Full throughput on P: 00..0F back to back, no bubbles.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            sel     = 1'b0;
            d_valid = 1'b1;
            d_in    = 8'(i);
            p_ready = 1'b1;
            q_ready = 1'b1;
            #1;
            chk($sformatf("stream%0d_d_ready", i), 32'(d_ready), 32'd1);
            @(posedge clk);
            #1;
            chk($sformatf("stream%0d_p_valid", i), 32'(p_valid), 32'd1);
            chk($sformatf("stream%0d_p_out", i),   32'(p_out),   32'(i));
        end
        @(negedge clk);
        d_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("stream_drain_p_valid", 32'(p_valid), 32'd0);

        // Asynchronous reset mid-cycle with both channels holding beats.
        @(negedge clk);
        sel     = 1'b1;
        d_valid = 1'b1;
        d_in    = 8'h77;
        p_ready = 1'b0;
        q_ready = 1'b0;
        @(negedge clk);
        sel  = 1'b0;
        d_in = 8'h66;
        @(posedge clk);
        #1;
        d_valid = 1'b0;
        chk("pre_rst_q_valid", 32'(q_valid), 32'd1);
        chk("pre_rst_p_valid", 32'(p_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle("post_rst_idle");

        // 17 handshakes on Q: counter wraps to 1 when built, else stays 0.
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            sel     = 1'b1;
            d_valid = 1'b1;
            d_in    = 8'(8'h80 + i);
            q_ready = 1'b1;
            p_ready = 1'b1;
            @(posedge clk);
            #1;
            chk($sformatf("qcnt_stream%0d_q_out", i), 32'(q_out), 32'(8'h80 + i));
        end
        @(negedge clk);
        d_valid = 1'b0;
        @(posedge clk);
        #1;
`ifdef DEMUX_CNT_EN
        exp_q_cnt = 4'd1;
`else
        exp_q_cnt = 4'd0;
`endif
        chk("cnt_q_valid", 32'(q_valid), 32'd0);
        chk("cnt_q_cnt",   32'(q_cnt),   32'(exp_q_cnt));
        chk("cnt_p_cnt",   32'(p_cnt),   32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_demux_reg

// File: doc/demux_reg.md
Name: demux_reg

Overview:
- Registered 1-to-2 demultiplexer; the opposite direction of the team's registered 2:1 operand mux.
- Routes one WIDTH-bit input stream to output channel P or Q according to `sel`, sampled with the input beat.
- Each output channel has a one-entry output register with a valid/ready handshake.
- Sits between the ALU result path and its two consumers, e.g. the writeback register and the flag/debug sink.

Parameters:
- WIDTH, 8, data width of input and both outputs.
- CNT_W, 8, width of the optional per-channel beat counters.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- d_in  in  WIDTH  input data.
- d_valid  in  1  input beat present.
- sel  in  1  0 routes the beat to P, 1 routes it to Q; sampled only when d_valid is high.
- d_ready  out  1  input accepted this cycle when high together with d_valid.
- p_out  out  WIDTH  channel P data.
- p_valid  out  1  channel P holds a beat.
- p_ready  in  1  channel P consumer accepts.
- q_out  out  WIDTH  channel Q data.
- q_valid  out  1  channel Q holds a beat.
- q_ready  in  1  channel Q consumer accepts.
- p_cnt  out  CNT_W  beats delivered on P (DEMUX_CNT_EN only).
- q_cnt  out  CNT_W  beats delivered on Q (DEMUX_CNT_EN only).

Behaviour:
- Reset, asynchronous on rst_n low:
  - p_valid = q_valid = 0; p_out = q_out = 0; counters = 0.
  - Reset takes effect immediately, mid-transfer included; held beats are discarded.
- Per-channel FSM, states EMPTY and FULL:
  - EMPTY -> FULL on an accepted input beat routed to that channel.
  - FULL -> EMPTY when `x_valid && x_ready` and no new beat is routed to that channel in the same cycle.
  - FULL -> FULL with the new data when the beat is drained and refilled in the same cycle. Full throughput: one beat per cycle per channel.
- Readiness: `d_ready = sel ? (!q_valid || q_ready) : (!p_valid || p_ready)`.
  - Combinational from sel, the selected channel's state and its ready.
  - The non-selected channel has no influence.
- Acceptance: `accept = d_valid && d_ready`.
  - On accept, d_in is registered into the selected channel on the next posedge, and its valid is 1 after that edge.
  - Latency is 1 cycle from accept to x_valid.
- Hold rule: while x_valid is 1 and x_ready is 0, x_out is stable and x_valid stays 1.
- Simultaneous events:
  - A P drain and a Q fill in the same cycle are independent; both occur.
  - A drain and a refill of the same channel keeps valid = 1 and loads the new data.
- Blocking: with the selected channel FULL and not ready, d_ready = 0 and the input stalls. The other channel keeps draining.
- Ordering: beats to the same channel stay in order. No ordering guarantee across channels.
- d_valid = 0: sel is ignored and no state change occurs from the input side.
- No combinational path from d_in to any output.

Optional Feature:
- Macro: DEMUX_CNT_EN.
- Defined:
  - p_cnt and q_cnt increment by 1 on each completed output handshake (`x_valid && x_ready`).
  - Each wraps from 2^CNT_W-1 to 0 silently.
  - Both reset to 0.
- Undefined:
  - Counter registers are not built.
  - p_cnt and q_cnt are tied to 0 and the ports remain, so the port list is unchanged.

Decomposition:
- Shared package `demux_pkg`:
  - Channel state enum `{CH_EMPTY, CH_FULL}`.
  - Constants `SEL_P = 1'b0`, `SEL_Q = 1'b1`.
  - Default WIDTH/CNT_W constants.
- One natural sub-module, `demux_out_slot`:
  - Single-entry valid/ready register: load, data, valid, ready, plus the optional counter.
  - Instantiated twice (P and Q).
  - The top holds only ready and select logic.

Test Plan:
- Reset and idle:
  - Assert rst_n = 0 mid-cycle with q_valid = 1 -> q_valid, p_valid, p_out, q_out drop to 0 immediately.
  - After release with d_valid = 0 -> all remain 0.
- Basic routing:
  - d_in = 8'hA5, sel = 0, d_valid = 1, p_ready = 1 -> next cycle p_out = A5, p_valid = 1, q_valid = 0.
  - Then 8'h3C with sel = 1 -> q_out = 3C one cycle later.
- Backpressure:
  - Fill P with 8'h11, hold p_ready = 0, present 8'h22 with sel = 0 -> d_ready = 0, p_out stays 11.
  - Present 8'h33 with sel = 1 -> accepted, q_out = 33.
- Full throughput:
  - Stream 8'h00..8'h0F to P with p_ready = 1 -> d_ready constantly 1.
  - p_out sequence is 00..0F, one per cycle, no bubbles.
- Simultaneous:
  - P FULL with 8'h40, p_ready = 1, new beat 8'h41 with sel = 0 in the same cycle -> p_valid stays 1 and p_out becomes 41.
- DEMUX_CNT_EN, CNT_W = 4:
  - 17 handshakes on Q -> q_cnt = 1 (wrapped) and p_cnt = 0.
  - Without the macro -> both read 0.
